// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per clock, WIDTH x WIDTH -> 2*WIDTH.
// Signed operands are multiplied as magnitudes and the sign is applied on the last step.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic [1:0]           dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // valid never depends combinationally on ready, and operands are sampled only then.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] acc_sum;
  logic [CW-1:0]      count;
  logic               neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               accept;
  logic               last_step;

  assign accept    = (state == IDLE) && in_valid;
  assign last_step = (state == RUN) && (count == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    dbg_state = state;
  end

  // Magnitudes fit in WIDTH unsigned bits, including |-2^(WIDTH-1)|.
  always_comb begin
    a_mag   = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag   = (is_signed && b[WIDTH-1]) ? -b : b;
    partial = {{WIDTH{1'b0}}, mcand} << count;
    acc_sum = acc + (mplier[0] ? partial : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      neg    <= 1'b0;
      p      <= '0;
    end else if (accept) begin
      mcand  <= a_mag;
      mplier <= b_mag;
      neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      acc    <= '0;
      count  <= '0;
    end else if (state == RUN) begin
      acc    <= acc_sum;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
      // Negating a zero sum yields zero, so no negative-zero case exists.
      if (last_step) p <= neg ? -acc_sum : acc_sum;
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier: WIDTH=4 directed vectors and WIDTH=8 random traffic,
// checked every cycle against a transaction-level arithmetic model.
module tb_seq_shift_add_multiplier;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst;
  logic [1:0] in_valid;
  logic [1:0] is_signed;
  logic [1:0] out_ready;
  logic [1:0] in_ready;
  logic [1:0] out_valid;
  logic [7:0] a [2];
  logic [7:0] b [2];
  logic [7:0]  p4;
  logic [15:0] p8;
  logic [1:0]  dbg4;
  logic [1:0]  dbg8;

  seq_shift_add_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0][3:0]), .b(b[0][3:0]), .is_signed(is_signed[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .p(p4), .dbg_state(dbg4)
  );

  seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .is_signed(is_signed[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .p(p8), .dbg_state(dbg8)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_mul(input int w, input logic [7:0] x,
                                          input logic [7:0] y, input bit s);
    longint xv, yv, pr, mask;
    mask = (64'sd1 <<< w) - 64'sd1;
    xv = longint'(x) & mask;
    yv = longint'(y) & mask;
    if (s && xv[w-1]) xv = xv - (64'sd1 <<< w);
    if (s && yv[w-1]) yv = yv - (64'sd1 <<< w);
    pr = xv * yv;
    return 16'(pr & ((64'sd1 <<< (2 * w)) - 64'sd1));
  endfunction

  int          wid [2]      = '{4, 8};
  bit          busy_m [2]   = '{0, 0};
  bit          valid_m [2]  = '{0, 0};
  logic [15:0] p_m [2]      = '{16'h0, 16'h0};
  logic [15:0] res_m [2]    = '{16'h0, 16'h0};
  int          acc_edge [2] = '{0, 0};
  int          in_cnt [2]   = '{0, 0};
  int          out_cnt [2]  = '{0, 0};
  logic [15:0] exp_q [$];
  int          cyc = 0;

  // Transaction-level model: result appears WIDTH edges after acceptance.
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst[i] === 1'b1) begin
        busy_m[i] = 1'b0; valid_m[i] = 1'b0; p_m[i] = 16'h0;
      end else if (!busy_m[i]) begin
        if (in_valid[i]) begin
          busy_m[i] = 1'b1; acc_edge[i] = cyc; in_cnt[i]++;
          res_m[i] = ref_mul(wid[i], a[i], b[i], is_signed[i]);
          if (i == 1) exp_q.push_back(res_m[i]);
        end
      end else if (!valid_m[i]) begin
        if (cyc == acc_edge[i] + wid[i]) begin
          valid_m[i] = 1'b1; p_m[i] = res_m[i];
        end
      end else if (out_ready[i]) begin
        busy_m[i] = 1'b0; valid_m[i] = 1'b0; out_cnt[i]++;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("in_ready%0d", wid[i]), 16'(in_ready[i]), 16'(!busy_m[i]));
        chk($sformatf("out_valid%0d", wid[i]), 16'(out_valid[i]), 16'(valid_m[i]));
        chk($sformatf("p%0d", wid[i]), (i == 1) ? p8 : {8'h00, p4}, p_m[i]);
      end
      // Scoreboard for the wide instance: retire in order on each output handshake.
      if (out_valid[1] && out_ready[1] && exp_q.size() > 0) begin
        chk("p8_scoreboard", p8, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int i, input logic [7:0] ta, input logic [7:0] tb_v, input bit s);
    int n;
    in_valid[i] = 1'b1; a[i] = ta; b[i] = tb_v; is_signed[i] = s;
    n = 0;
    @(negedge clk);
    while (!in_ready[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[i]) chk("send_timeout", 16'(in_ready[i]), 16'h1);
    @(posedge clk);
    #1;
    in_valid[i] = 1'b0;
    a[i] = 8'($urandom); b[i] = 8'($urandom); is_signed[i] = 1'($urandom);
  endtask

  task automatic txn4(input logic [3:0] ta, input logic [3:0] tb_v, input bit s,
                      input logic [7:0] expv, input int hold);
    int n;
    out_ready[0] = (hold == 0);
    send(0, {4'h0, ta}, {4'h0, tb_v}, s);
    n = 0;
    @(negedge clk);
    while (!out_valid[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("w4_out_valid_seen", 16'(out_valid[0]), 16'h1);
    chk("w4_p_literal", {8'h00, p4}, {8'h00, expv});
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        chk("hold_out_valid", 16'(out_valid[0]), 16'h1);
        chk("hold_in_ready", 16'(in_ready[0]), 16'h0);
        chk("hold_p", {8'h00, p4}, {8'h00, expv});
      end
      @(posedge clk);
      #1;
      out_ready[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("release_in_ready", 16'(in_ready[0]), 16'h1);
      chk("release_out_valid", 16'(out_valid[0]), 16'h0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit done8;
    int n;
    rst = 2'b11; in_valid = 2'b00; is_signed = 2'b00; out_ready = 2'b11;
    a[0] = 8'h0; a[1] = 8'h0; b[0] = 8'h0; b[1] = 8'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 2'b00;
    chk_en = 1'b1;

    // Model pins against hand-computed products.
    chk("pin_u15x15", ref_mul(4, 8'hF, 8'hF, 1'b0), 16'h00E1);
    chk("pin_s_m8xm8", ref_mul(4, 8'h8, 8'h8, 1'b1), 16'h0040);
    chk("pin_s_m3x5", ref_mul(4, 8'hD, 8'h5, 1'b1), 16'h00F1);
    chk("pin_w8_m128sq", ref_mul(8, 8'h80, 8'h80, 1'b1), 16'h4000);
    chk("pin_w8_255sq", ref_mul(8, 8'hFF, 8'hFF, 1'b0), 16'hFE01);
    chk("pin_w8_m128x127", ref_mul(8, 8'h80, 8'h7F, 1'b1), 16'hC080);

    // WIDTH=4 directed vectors
    txn4(4'hF, 4'hF, 1'b0, 8'hE1, 0);
    txn4(4'h8, 4'h8, 1'b1, 8'h40, 0);
    txn4(4'hD, 4'h5, 1'b1, 8'hF1, 0);
    txn4(4'h7, 4'hF, 1'b1, 8'hF9, 0);
    txn4(4'h0, 4'hD, 1'b0, 8'h00, 0);
    txn4(4'h0, 4'hD, 1'b1, 8'h00, 0);
    txn4(4'h1, 4'h9, 1'b0, 8'h09, 0);
    txn4(4'h8, 4'h1, 1'b1, 8'hF8, 0);
    txn4(4'h6, 4'h7, 1'b0, 8'h2A, 10);

    // Reset two edges into RUN drops the transaction.
    send(0, 8'h09, 8'h09, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 16'(in_ready[0]), 16'h1);
    chk("rst_out_valid", 16'(out_valid[0]), 16'h0);
    chk("rst_p", {8'h00, p4}, 16'h0000);

    // in_valid together with rst: nothing accepted.
    @(posedge clk);
    #1;
    rst[0] = 1'b1; in_valid[0] = 1'b1; a[0] = 8'h5; b[0] = 8'h5; is_signed[0] = 1'b0;
    @(posedge clk);
    #1;
    rst[0] = 1'b0; in_valid[0] = 1'b0;
    @(negedge clk);
    chk("rst_wins_in_ready", 16'(in_ready[0]), 16'h1);
    @(posedge clk);
    #1;
    txn4(4'h2, 4'h3, 1'b0, 8'h06, 0);

    // WIDTH=8 random traffic with random output stalls.
    done8 = 1'b0;
    fork
      begin
        for (int t = 0; t < 1000; t++)
          send(1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        done8 = 1'b1;
      end
      begin
        while (!done8) begin
          @(posedge clk);
          #1;
          out_ready[1] = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready[1] = 1'b1;
    n = 0;
    while (busy_m[1] && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("w8_drain", 16'(busy_m[1]), 16'h0);
    chk("w8_in_count", 16'(in_cnt[1]), 16'd1000);
    chk("w8_out_count", 16'(out_cnt[1]), 16'(in_cnt[1]));
    chk("w8_queue_empty", 16'(exp_q.size()), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
